edge_generator: RTL and testbench
=================================

EDGE_GENERATOR -- requirements
Module: edge_generator

Interface
REQ-001 Parameter MIN_HIGH, default 4: minimum cycles sig_out SHALL stay high once raised (legal range 1..2^CNT_W-1).
REQ-002 Parameter MIN_LOW, default 4: minimum cycles sig_out SHALL stay low once lowered (legal range 1..2^CNT_W-1).
REQ-003 Parameter CNT_W, default 8: hold counter width.
REQ-004 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 rise_req  input  1  one-cycle request to drive sig_out high.
REQ-007 fall_req  input  1  one-cycle request to drive sig_out low.
REQ-008 sig_out  output  1  generated level, registered.
REQ-009 rising  output  1  one-cycle pulse, high in the first cycle sig_out is 1 after being 0.
REQ-010 falling  output  1  one-cycle pulse, high in the first cycle sig_out is 0 after being 1.
REQ-011 busy  output  1  high while a hold time is running or a request is pending.

Function
REQ-012 FSM states SHALL be LOW_IDLE, LOW_HOLD, HIGH_HOLD, HIGH_IDLE; sig_out = 1 exactly in HIGH_HOLD/HIGH_IDLE.
REQ-013 rise_req in LOW_IDLE SHALL move to HIGH_HOLD at the next edge (latency 1 cycle) and load the hold counter for MIN_HIGH cycles.
REQ-014 fall_req in HIGH_IDLE SHALL move to LOW_HOLD at the next edge and load the hold counter for MIN_LOW cycles.
REQ-015 HIGH_HOLD SHALL last exactly MIN_HIGH cycles, then go to HIGH_IDLE, or to LOW_HOLD directly if a fall is pending; LOW_HOLD symmetric with MIN_LOW.
REQ-016 Opposite-direction request during a hold SHALL set a one-entry pending flag; execution occurs on the first cycle the hold permits, so sig_out is high (low) for exactly MIN_HIGH (MIN_LOW) cycles.
REQ-017 Same-direction request while pending is set (i.e. returning to current level) SHALL clear pending.
REQ-018 Request equal to the current level with no pending SHALL be ignored.
REQ-019 rise_req and fall_req asserted together SHALL both be ignored; state and pending unchanged.
REQ-020 rising/falling SHALL be registered, asserted together with the sig_out transition, never both high.
REQ-021 busy SHALL equal (state is LOW_HOLD or HIGH_HOLD) or pending.
REQ-022 Hold counter SHALL never wrap; it stops at zero.

Reset
REQ-023 reset_n low SHALL immediately force LOW_IDLE, sig_out=0, rising=0, falling=0, busy=0, pending=0, counter=0, regardless of clock.
REQ-024 Reset mid-hold or with pending set SHALL discard the hold and pending request; first legal request after release SHALL be rise_req, honoured with 1-cycle latency.
REQ-025 reset release SHALL produce no rising or falling pulse.

Configuration
REQ-026 Macro EDGE_GENERATOR_DROP_CNT_EN defined: add output drop_count, 8 bits, reset 0, incremented by one per ignored event (REQ-018, REQ-019, and each pending cancellation of REQ-017), saturating at 255.
REQ-027 Macro undefined: drop_count port and its logic SHALL be absent; all other behaviour identical.

Verification (MIN_HIGH=3, MIN_LOW=2)
REQ-028 rise_req at cycle 10 from LOW_IDLE -> sig_out=1 cycles 11..; rising=1 only at cycle 11; busy=1 cycles 11-13, 0 at 14.
REQ-029 rise_req cycle 10, fall_req cycle 11 -> sig_out high exactly cycles 11-13, low at 14, falling=1 at 14, low until at least cycle 15.
REQ-030 rise_req cycle 10, fall_req cycle 11, rise_req cycle 12 -> pending cancelled, sig_out stays high, busy=0 at 14; drop_count=1 with macro.
REQ-031 rise_req and fall_req both at cycle 10 in LOW_IDLE -> sig_out stays 0, no pulses; drop_count=1 with macro; 300 such events -> drop_count=255.
REQ-032 reset_n low mid-HIGH_HOLD between edges -> sig_out, busy, pending 0 before next edge; no falling pulse; rise_req after release -> sig_out=1 one cycle later.

Source files
------------

// File: rtl/edge_generator.sv
// Edge generator: registered level with minimum high/low hold times, one-entry pending request.
// Optional EDGE_GENERATOR_DROP_CNT_EN adds an 8-bit saturating count of ignored requests.
module edge_generator #(
    parameter int unsigned MIN_HIGH = 4,
    parameter int unsigned MIN_LOW  = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rise_req,
    input  logic       fall_req,
    output logic       sig_out,
    output logic       rising,
    output logic       falling,
`ifdef EDGE_GENERATOR_DROP_CNT_EN
    output logic [7:0] drop_count,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {
        LOW_IDLE,
        LOW_HOLD,
        HIGH_HOLD,
        HIGH_IDLE
    } state_t;

    // Counter holds remaining cycles minus one, so zero marks the last hold cycle.
    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(MIN_HIGH - 1);
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(MIN_LOW - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pending, pending_n;
    logic             drop_ev;
    logic             want_rise, want_fall, both_req;
    logic             high_n, hold_n;

    assign want_rise = rise_req & ~fall_req;
    assign want_fall = fall_req & ~rise_req;
    assign both_req  = rise_req & fall_req;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pending_n = pending;
        drop_ev   = 1'b0;
        case (state)
            LOW_IDLE: begin
                if (want_rise) begin
                    state_n = HIGH_HOLD;
                    cnt_n   = HIGH_LOAD;
                end else if (rise_req | fall_req) begin
                    drop_ev = 1'b1;
                end
            end
            HIGH_IDLE: begin
                if (want_fall) begin
                    state_n = LOW_HOLD;
                    cnt_n   = LOW_LOAD;
                end else if (rise_req | fall_req) begin
                    drop_ev = 1'b1;
                end
            end
            HIGH_HOLD: begin
                if (want_fall) begin
                    pending_n = 1'b1;
                end else if (want_rise) begin
                    pending_n = 1'b0;
                    drop_ev   = 1'b1;
                end else if (both_req) begin
                    drop_ev = 1'b1;
                end
                if (cnt == '0) begin
                    if (pending_n) begin
                        state_n   = LOW_HOLD;
                        cnt_n     = LOW_LOAD;
                        pending_n = 1'b0;
                    end else begin
                        state_n = HIGH_IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            LOW_HOLD: begin
                if (want_rise) begin
                    pending_n = 1'b1;
                end else if (want_fall) begin
                    pending_n = 1'b0;
                    drop_ev   = 1'b1;
                end else if (both_req) begin
                    drop_ev = 1'b1;
                end
                if (cnt == '0) begin
                    if (pending_n) begin
                        state_n   = HIGH_HOLD;
                        cnt_n     = HIGH_LOAD;
                        pending_n = 1'b0;
                    end else begin
                        state_n = LOW_IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n   = LOW_IDLE;
                cnt_n     = '0;
                pending_n = 1'b0;
            end
        endcase
    end

    assign high_n = (state_n == HIGH_HOLD) || (state_n == HIGH_IDLE);
    assign hold_n = (state_n == HIGH_HOLD) || (state_n == LOW_HOLD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= LOW_IDLE;
            cnt     <= '0;
            pending <= 1'b0;
            sig_out <= 1'b0;
            rising  <= 1'b0;
            falling <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pending <= pending_n;
            sig_out <= high_n;
            rising  <= high_n & ~sig_out;
            falling <= ~high_n & sig_out;
            busy    <= hold_n | pending_n;
        end
    end

`ifdef EDGE_GENERATOR_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (drop_ev && (drop_count != '1)) begin
            drop_count <= drop_count + 1'b1;
        end
    end
`else
    logic unused_drop_ev;
    assign unused_drop_ev = drop_ev;
`endif

endmodule

// File: tb/tb_edge_generator.sv
// Self-checking bench for edge_generator (MIN_HIGH=3, MIN_LOW=2) against an age-based level model.
module tb_edge_generator;

    localparam int MH = 3;
    localparam int ML = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rise_req = 1'b0;
    logic       fall_req = 1'b0;
    logic       sig_out, rising, falling, busy;
`ifdef EDGE_GENERATOR_DROP_CNT_EN
    logic [7:0] drop_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Model: current level, cycles spent at it, whether it was entered by a transition.
    bit m_level, m_changed, m_pend, m_rise, m_fall;
    int m_age, m_drop;

    edge_generator #(.MIN_HIGH(MH), .MIN_LOW(ML), .CNT_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rise_req  (rise_req),
        .fall_req  (fall_req),
        .sig_out   (sig_out),
        .rising    (rising),
        .falling   (falling),
`ifdef EDGE_GENERATOR_DROP_CNT_EN
        .drop_count(drop_count),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_level = 0; m_changed = 0; m_pend = 0; m_rise = 0; m_fall = 0;
        m_age = 1000; m_drop = 0;
    endtask

    task automatic drop_inc();
        if (m_drop < 255) m_drop++;
    endtask

    task automatic model_edge(input bit r, input bit f);
        int mn;
        bit in_hold, want_opp, want_same, toggle;
        mn        = m_level ? MH : ML;
        in_hold   = m_changed && (m_age <= mn);
        want_opp  = m_level ? (f && !r) : (r && !f);
        want_same = m_level ? (r && !f) : (f && !r);
        toggle    = 0;
        m_rise    = 0;
        m_fall    = 0;
        if (in_hold) begin
            if (want_opp) m_pend = 1;
            else if (want_same) begin m_pend = 0; drop_inc(); end
            else if (r && f) drop_inc();
            if (m_age == mn && m_pend) begin toggle = 1; m_pend = 0; end
        end else begin
            if (want_opp) toggle = 1;
            else if (r || f) drop_inc();
        end
        if (toggle) begin
            m_level   = !m_level;
            m_age     = 1;
            m_changed = 1;
            m_rise    = m_level;
            m_fall    = !m_level;
        end else if (m_age < 1000) begin
            m_age++;
        end
    endtask

    function automatic bit model_busy();
        int mn;
        mn = m_level ? MH : ML;
        return (m_changed && (m_age <= mn)) || m_pend;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".sig_out"}, {7'd0, sig_out}, {7'd0, m_level});
        check({tag, ".rising"},  {7'd0, rising},  {7'd0, m_rise});
        check({tag, ".falling"}, {7'd0, falling}, {7'd0, m_fall});
        check({tag, ".busy"},    {7'd0, busy},    {7'd0, model_busy()});
`ifdef EDGE_GENERATOR_DROP_CNT_EN
        check({tag, ".drop_count"}, drop_count, 8'(m_drop));
`endif
    endtask

    task automatic step(input string tag, input bit r, input bit f);
        rise_req = r;
        fall_req = f;
        @(posedge clk);
        model_edge(r, f);
        #1;
        rise_req = 0;
        fall_req = 0;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0);
    endtask

    // Pulls reset low between edges, checks the asynchronous clear, releases on a falling edge.
    task automatic async_reset(input string tag);
        #2;
        reset_n = 0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset_hold");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        idle("post_reset", 3);

        step("single_rise", 1, 0);
        idle("single_rise_hold", 5);
        step("fall_idle", 0, 1);
        idle("fall_hold", 4);

        step("pend_fall.r", 1, 0);
        step("pend_fall.f", 0, 1);
        idle("pend_fall.wait", 6);

        step("cancel.r", 1, 0);
        step("cancel.f", 0, 1);
        step("cancel.r2", 1, 0);
        idle("cancel.wait", 4);
        step("drop_same_high", 1, 0);
        step("both_high_idle", 1, 1);
        step("fall_from_idle", 0, 1);
        step("pend_rise_in_low_hold", 1, 0);
        idle("pend_rise.wait", 6);
        step("fall_last", 0, 1);
        idle("fall_last.wait", 4);

        step("both_low_idle", 1, 1);
        idle("both_low_idle.wait", 2);

        step("mid_hold.r", 1, 0);
        async_reset("mid_hold");
        idle("after_reset", 2);
        step("rise_after_reset", 1, 0);
        step("pend_then_reset", 0, 1);
        async_reset("pend_reset");
        idle("after_pend_reset", 5);

        for (int i = 0; i < 300; i++) step("saturate", 1, 1);
        check("saturate.model_drop", 8'(m_drop), 8'd255);

        for (int i = 0; i < 800; i++) begin
            int unsigned x;
            x = $urandom_range(0, 99);
            if (x < 22)      step("rand", 1, 0);
            else if (x < 44) step("rand", 0, 1);
            else if (x < 49) step("rand", 1, 1);
            else if (x == 99) async_reset("rand");
            else             step("rand", 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
